wb_dual_arbiter: RTL
====================

# wb_dual_arbiter

Two-master, one-slave Wishbone (pipelined) arbiter that shares a single on-chip memory (or any pipelined single-cycle slave) between two requesters, e.g. the CPU data port (A) and a debug/DMA port (B). Ownership is granted per bus cycle (`cyc`) and held until the owner drops `cyc`. Outstanding transactions are tracked so that acks are routed only to the owner, and stray acks are discarded. The block sits directly between the masters and the memory slave.

## Interface
- `AW`, 15, address width
- `DW`, 32, data width
- `LGMAX`, 4, log2 of the maximum outstanding requests per owner; the owner is stalled at 2^LGMAX−1 outstanding
- `RR`, 1, 1 = alternate on contention, 0 = A always wins contention

Ports:
- `i_clk` in 1 — the single clock
- `i_rst` in 1 — reset, synchronous, active-high
- `i_a_cyc`, `i_a_stb`, `i_a_we` in 1 each — master A control
- `i_a_addr` in AW, `i_a_data` in DW — master A request
- `o_a_ack`, `o_a_stall`, `o_a_err` out 1 each — master A response
- `o_a_data` out DW — master A read data (= `i_wb_data`)
- `i_b_*` / `o_b_*` — same set for master B
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each — slave control
- `o_wb_addr` out AW, `o_wb_data` out DW — slave request
- `i_wb_ack`, `i_wb_stall`, `i_wb_err` in 1 each — slave response
- `i_wb_data` in DW — slave read data

## Operation
- States (registered `owner`): IDLE, OWN_A, OWN_B. Also registered: `last` (last granted master), `count` (LGMAX bits).
- Transitions out of IDLE:
  - Only A `cyc` → OWN_A; only B `cyc` → OWN_B.
  - Both: RR=1 grants the master that is not `last`; RR=0 grants A.
- OWN_X → OWN_Y when X drops `cyc` and Y `cyc` is high (direct handoff, no IDLE cycle); → IDLE when X drops `cyc` and Y is idle.
- Slave outputs are a combinational mux of the owner's inputs:
  - `o_wb_cyc` = owner `cyc`.
  - `o_wb_stb` = owner `cyc` & `stb` & !full.
  - In IDLE, `o_wb_cyc` = `o_wb_stb` = 0.
- `o_X_stall` = (owner≠X) | full | `i_wb_stall`. A non-owner is always stalled.
- `count` update:
  - +1 on accepted strobe (`o_wb_stb` & !`i_wb_stall`).
  - −1 on `i_wb_ack` with count>0.
  - Both in the same cycle → unchanged.
  - full = (count == 2^LGMAX−1).
- `o_X_ack` = `i_wb_ack` & (owner==X) & (count>0). Any ack arriving at count 0 is dropped.
- `o_X_err` = `i_wb_err` & (owner==X). An err clears `count` to 0 and drops all further acks until new strobes are issued.
- Owner dropping `cyc` with count>0: abort. `count` clears to 0, `o_wb_cyc` falls that same cycle, and late acks are not forwarded to either master.

## Timing
- Reset values:
  - `owner` = IDLE, `count` = 0, `last` = B, so A wins the first contention.
  - All `o_*_ack`/`o_*_err`/`o_wb_cyc`/`o_wb_stb` = 0; both `o_*_stall` = 1.
- Grant latency is one cycle from IDLE. Master `cyc`+`stb` raised at cycle n → stalled at n, `o_wb_stb` at n+1. With a single-cycle slave, `o_X_ack` arrives at n+2.
- Handoff: owner drops `cyc` at n → new owner's strobe is forwarded at n+1.
- Throughput while owned: one request per cycle. Ack is combinational from `i_wb_ack`, adding zero latency.
- Reset mid-transfer: state clears on the next edge. Acks returning after reset are dropped because count = 0.
- A non-owner holding `cyc` is never starved under RR=1: it is granted at the owner's next `cyc` release.

## Structure
- Shared package `wbarb_pkg`: owner state encoding (IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10) and the full-threshold function of LGMAX.
- Single module. The counter and mux are inline; no sub-module.

## Test plan
- Reset, then A `cyc`/`stb` read at address 0x0010 → A stalled 1 cycle, `o_wb_stb` next cycle, `o_a_ack` plus memory data 2 cycles after the request; B stays stalled throughout.
- Both masters raise `cyc` in the same cycle with RR=1 → A granted first. A releases and B is granted the next cycle. A re-raises while B owns → A waits, and gets the grant immediately after B releases.
- A issues 16 back-to-back strobes with LGMAX=4 and acks delayed → stall asserts after 15 outstanding, no 16th strobe reaches the slave, and the 16th is issued once the first ack lands.
- Owner drops `cyc` with 3 outstanding → `o_wb_cyc` falls the same cycle, count = 0, and the 3 late acks reach neither master.
- `i_wb_err` on the 2nd of 4 pipelined reads → `o_a_err` pulses once, remaining acks dropped, count = 0.
- `i_rst` asserted mid-burst → next cycle owner = IDLE, both stalls = 1; a pending ack 1 cycle later is not forwarded.

Source files
------------

// File: rtl/wb_dual_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: owner state
// encoding and the outstanding-request ceiling.
package wbarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } owner_e;

    // The owner is stalled once this many requests are outstanding.
    function automatic int unsigned full_level(input int unsigned lg);
        return (32'd1 << lg) - 32'd1;
    endfunction

endpackage

// File: rtl/wb_dual_arbiter_if.sv
// Pipelined Wishbone bus bundle; a master drives the request side and a
// slave drives the response side.
interface wb_dual_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 32
) ();

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          stall;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata,
        input  ack, stall, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata,
        output ack, stall, err, rdata
    );

endinterface

// File: rtl/wb_dual_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter. Ownership is held per
// bus cycle; outstanding requests are counted so acks reach only the owner.
module wb_dual_arbiter
    import wbarb_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 32,
    parameter int LGMAX = 4,
    parameter bit RR    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wb_dual_arbiter_if.slave      a_if,
    wb_dual_arbiter_if.slave      b_if,
    wb_dual_arbiter_if.master     wb_if
);

    localparam logic [LGMAX-1:0] FULL_LVL = LGMAX'(full_level(LGMAX));

    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    logic [LGMAX-1:0] count_q, count_d;

    logic          own_cyc;
    logic          own_stb;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          full;
    logic          stb_fwd;
    logic          accept;
    logic          ack_ok;
    logic          abort;

    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (owner_q)
            OWN_A: begin
                own_cyc   = a_if.cyc;
                own_stb   = a_if.stb;
                own_we    = a_if.we;
                own_addr  = a_if.addr;
                own_wdata = a_if.wdata;
            end
            OWN_B: begin
                own_cyc   = b_if.cyc;
                own_stb   = b_if.stb;
                own_we    = b_if.we;
                own_addr  = b_if.addr;
                own_wdata = b_if.wdata;
            end
            default: ;
        endcase
    end

    assign full    = (count_q == FULL_LVL);
    assign stb_fwd = own_cyc & own_stb & ~full;
    assign accept  = stb_fwd & ~wb_if.stall;
    assign ack_ok  = wb_if.ack & (count_q != '0);
    // The owner releasing cyc with requests in flight abandons them.
    assign abort   = (owner_q != IDLE) & ~own_cyc;

    assign wb_if.cyc   = own_cyc;
    assign wb_if.stb   = stb_fwd;
    assign wb_if.we    = own_we;
    assign wb_if.addr  = own_addr;
    assign wb_if.wdata = own_wdata;

    assign a_if.stall = (owner_q != OWN_A) | full | wb_if.stall;
    assign a_if.ack   = ack_ok & (owner_q == OWN_A);
    assign a_if.err   = wb_if.err & (owner_q == OWN_A);
    assign a_if.rdata = wb_if.rdata;

    assign b_if.stall = (owner_q != OWN_B) | full | wb_if.stall;
    assign b_if.ack   = ack_ok & (owner_q == OWN_B);
    assign b_if.err   = wb_if.err & (owner_q == OWN_B);
    assign b_if.rdata = wb_if.rdata;

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        case (owner_q)
            IDLE: begin
                if (a_if.cyc && b_if.cyc)
                    owner_d = (RR && (last_q == OWN_A)) ? OWN_B : OWN_A;
                else if (a_if.cyc)
                    owner_d = OWN_A;
                else if (b_if.cyc)
                    owner_d = OWN_B;
            end
            OWN_A: if (!a_if.cyc) owner_d = b_if.cyc ? OWN_B : IDLE;
            OWN_B: if (!b_if.cyc) owner_d = a_if.cyc ? OWN_A : IDLE;
            default: owner_d = IDLE;
        endcase
        if ((owner_d != IDLE) && (owner_d != owner_q))
            last_d = owner_d;
    end

    // A bus error invalidates everything in flight, like an abort.
    always_comb begin
        count_d = count_q;
        if (abort || wb_if.err)
            count_d = '0;
        else if (accept && !ack_ok)
            count_d = count_q + 1'b1;
        else if (!accept && ack_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_q <= IDLE;
            last_q  <= OWN_B;
            count_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule
